turn_timer_multi: RTL
=====================

# turn_timer_multi

Parametrised per-turn countdown timer for the board-game datapath. It counts whole seconds from a system-clock prescaler and rotates the active turn among `NUM_PLAYERS` players. On expiry it emits a one-cycle timeout pulse and a pseudo-random fallback column, and it drives two active-low seven-segment digits with the remaining time. It sits between the game FSM, which supplies start, move-done, game-over and pause, and the board/display logic.

## Interface
Parameters:
- `CLK_HZ`, 25_000_000: clock cycles per second tick; must be ≥ 2.
- `TURN_SECONDS`, 15: turn length in seconds, range 1..99.
- `NUM_PLAYERS`, 2: number of players in the rotation, range 2..8.
- `WARN_SECONDS`, 5: `warn` asserts when remaining ≤ this value; 0 disables.
- `POS_MAX`, 7: fallback position range is 1..POS_MAX, range 1..255.
- Localparams: `PW = $clog2(NUM_PLAYERS)`, `POS_W = 8`, `CW = $clog2(CLK_HZ)`.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous reset, active-low.
- `start`, in, 1: level-sampled; (re)starts the game at player 0.
- `move_done`, in, 1: current player committed a move.
- `game_over`, in, 1: game finished.
- `pause`, in, 1: freeze the countdown while high.
- `active_player`, out, PW: index of the player whose turn it is.
- `timeout`, out, 1: one-cycle pulse when a turn expires.
- `fallback_pos`, out, 8: position to auto-play; valid from the `timeout` cycle onward.
- `remaining`, out, 7: seconds left in the turn, binary.
- `bcd_tens`, out, 4; `bcd_units`, out, 4: BCD digits of the displayed value.
- `seg_tens`, out, 7; `seg_units`, out, 7: active-low segments, bit order gfedcba.
- `warn`, out, 1: low-time warning.
- `running`, out, 1: high while in RUN.

## Operation
- FSM states: IDLE, RUN, PAUSED, OVER. Reset state is IDLE.
- Transition priority, highest first: `game_over` > `start` > `pause` > `move_done` > tick.
- `game_over` high: go to OVER from any state. OVER is left only by `start` or reset.
- `start` in any state except while `game_over` is high: go to RUN with `active_player=0`, `remaining=TURN_SECONDS`, prescaler=0.
- RUN with `pause` high: go to PAUSED. Prescaler and `remaining` hold. Return to RUN on `pause` low, resuming the same prescaler value.
- `move_done` in PAUSED, IDLE or OVER is ignored.
- RUN with `move_done`:
  - `remaining` reloads to TURN_SECONDS and the prescaler clears.
  - `active_player` advances to `(p+1) mod NUM_PLAYERS`.
  - No `timeout` is issued, even when it coincides with an expiring tick.
- Prescaler counts 0..CLK_HZ-1 in RUN only. The tick is the cycle where the prescaler equals CLK_HZ-1; the prescaler then wraps to 0.
- Tick with `remaining > 1`: decrement `remaining`.
- Tick with `remaining == 1` (expiry):
  - `timeout` pulses.
  - `fallback_pos` latches `(lfsr % POS_MAX) + 1`.
  - `remaining` reloads and the player advances.
  - State stays RUN.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Shifts every clock in all states. Reset seed is 8'h01, so the value is never 0.
- Displayed value is `remaining` in RUN/PAUSED and 0 in IDLE/OVER.
  - `bcd_tens = value/10`, `bcd_units = value%10`.
- Segment encoding for 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Both digits are blank (1111111) in IDLE.
  - Both digits show "00" in OVER.
- `warn = (RUN or PAUSED) && remaining <= WARN_SECONDS && WARN_SECONDS != 0`.

## Timing
- All state, `remaining`, `active_player`, `timeout` and `fallback_pos` are registered. BCD, segment and `warn` outputs are combinational from registers.
- Latency: any control input sampled at edge N takes effect on outputs after edge N.
- `timeout` is high for exactly the one cycle following the expiry edge.
- Reset values:
  - state=IDLE, `active_player=0`, `remaining=TURN_SECONDS`, `timeout=0`, `fallback_pos=0`.
  - `running=0`, `warn=0`, BCD = 0/0, segments blank.
- Reset mid-turn: all of the above applies immediately and asynchronously. No `timeout` is issued.
- Turn duration from `start` or `move_done` to `timeout` is exactly `TURN_SECONDS*CLK_HZ` cycles, excluding paused cycles.

## Test plan
Bench parameters: CLK_HZ=4, TURN_SECONDS=3, NUM_PLAYERS=3, WARN_SECONDS=1, POS_MAX=7.
- Reset, then `start` for 1 cycle → `running=1`, `remaining=3`, `seg_units=0110000`; `remaining` reads 2 after 4 cycles and 1 after 8; `timeout` pulses once at cycle 12; `active_player=1`; `fallback_pos` lies in 1..7.
- Three consecutive expiries → `active_player` sequence 1, 2, 0; exactly three `timeout` pulses, each 1 cycle wide, 12 cycles apart.
- `move_done` asserted in the same cycle as the expiry tick → no `timeout`; `remaining=3`; player advances once.
- `pause` held for 10 cycles at `remaining=2` → `remaining` and `warn` hold; after release, `timeout` arrives 10 cycles later than unpaused.
- `game_over` during RUN → OVER; `seg_tens` and `seg_units` both 1000000; `running=0`; subsequent `move_done` and ticks have no effect; `start` returns to RUN at player 0.
- `rst` low mid-turn with `remaining=1` → no `timeout`; segments blank; `remaining=3` while reset is held.

Source files
------------

// File: rtl/turn_timer_multi.sv
// Per-turn countdown timer with player rotation, expiry pulse, pseudo-random
// fallback position and a two-digit active-low seven-segment readout.
module turn_timer_multi #(
  parameter  int CLK_HZ       = 25_000_000,
  parameter  int TURN_SECONDS = 15,
  parameter  int NUM_PLAYERS  = 2,
  parameter  int WARN_SECONDS = 5,
  parameter  int POS_MAX      = 7,
  localparam int PW           = $clog2(NUM_PLAYERS),
  localparam int POS_W        = 8,
  localparam int CW           = $clog2(CLK_HZ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             move_done,
  input  logic             game_over,
  input  logic             pause,
  output logic [PW-1:0]    active_player,
  output logic             timeout,
  output logic [POS_W-1:0] fallback_pos,
  output logic [6:0]       remaining,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_units,
  output logic [6:0]       seg_tens,
  output logic [6:0]       seg_units,
  output logic             warn,
  output logic             running
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_OVER
  } state_e;

  localparam logic [6:0]       TURN_R      = 7'(TURN_SECONDS);
  localparam logic [6:0]       WARN_R      = 7'(WARN_SECONDS);
  localparam logic [CW-1:0]    PRESC_MAX   = CW'(CLK_HZ - 1);
  localparam logic [PW-1:0]    LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [POS_W-1:0] POS_MAX_R   = POS_W'(POS_MAX);
  localparam logic [6:0]       SEG_BLANK   = 7'b1111111;

  state_e           state_q, state_d;
  logic [PW-1:0]    player_q, player_d;
  logic [6:0]       remaining_q, remaining_d;
  logic [CW-1:0]    presc_q, presc_d;
  logic             timeout_q, timeout_d;
  logic [POS_W-1:0] fallback_q, fallback_d;
  logic [7:0]       lfsr_q, lfsr_d;

  logic             count_en;
  logic [PW-1:0]    next_player;
  logic [POS_W-1:0] pos_pick;
  logic [6:0]       disp_val;

  assign next_player = (player_q == LAST_PLAYER) ? '0 : player_q + PW'(1);
  assign pos_pick    = (lfsr_q % POS_MAX_R) + POS_W'(1);

  // Fibonacci taps 8,6,5,4; the all-zero state is unreachable from the seed.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    player_d    = player_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    timeout_d   = 1'b0;
    fallback_d  = fallback_q;
    count_en    = 1'b0;

    if (game_over) begin
      state_d = S_OVER;
    end else if (start) begin
      state_d     = S_RUN;
      player_d    = '0;
      remaining_d = TURN_R;
      presc_d     = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (move_done) begin
            remaining_d = TURN_R;
            presc_d     = '0;
            player_d    = next_player;
          end else begin
            count_en = 1'b1;
          end
        end
        // The resume cycle counts, so a pause of N cycles delays expiry by N.
        S_PAUSED: begin
          if (!pause) begin
            state_d  = S_RUN;
            count_en = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (count_en) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (remaining_q > 7'd1) begin
          remaining_d = remaining_q - 7'd1;
        end else begin
          timeout_d   = 1'b1;
          fallback_d  = pos_pick;
          remaining_d = TURN_R;
          player_d    = next_player;
        end
      end else begin
        presc_d = presc_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      player_q    <= '0;
      remaining_q <= TURN_R;
      presc_q     <= '0;
      timeout_q   <= 1'b0;
      fallback_q  <= '0;
      lfsr_q      <= 8'h01;
    end else begin
      state_q     <= state_d;
      player_q    <= player_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      timeout_q   <= timeout_d;
      fallback_q  <= fallback_d;
      lfsr_q      <= lfsr_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    unique case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  assign running  = (state_q == S_RUN);
  assign disp_val = (state_q == S_RUN || state_q == S_PAUSED) ? remaining_q : 7'd0;

  assign bcd_tens  = 4'(disp_val / 7'd10);
  assign bcd_units = 4'(disp_val % 7'd10);
  assign seg_tens  = (state_q == S_IDLE) ? SEG_BLANK : seg7(bcd_tens);
  assign seg_units = (state_q == S_IDLE) ? SEG_BLANK : seg7(bcd_units);

  assign warn = (state_q == S_RUN || state_q == S_PAUSED) &&
                (remaining_q <= WARN_R) && (WARN_SECONDS != 0);

  assign active_player = player_q;
  assign timeout       = timeout_q;
  assign fallback_pos  = fallback_q;
  assign remaining     = remaining_q;

endmodule
